div_unit: RTL

Multi-cycle 32-bit integer divider for the MIPS datapath. It performs DIV (signed) and DIVU (unsigned), the inverse of the ALU's single-cycle multiply path, and produces a quotient (LO) and remainder (HI) for the HI/LO register file. It sits beside the ALU in the execute stage. The pipeline stalls on `busy`, and the result is written to HI/LO when `valid` rises.

---
 rtl/div_unit_pkg.sv | 12 +
 rtl/div_step.sv | 28 ++
 rtl/div_unit.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared widths and sign helper for the multi-cycle divider
package div_unit_pkg;

  localparam int DIV_W = 32;
  localparam int CNT_W = 6;
  localparam logic [CNT_W-1:0] CNT_LAST = 6'd31;

  function automatic logic [DIV_W-1:0] cond_neg(input logic [DIV_W-1:0] x, input logic neg);
    return neg ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one radix-2 restoring division iteration (combinational)
module div_step
  import div_unit_pkg::*;
#(
  parameter int DATA_W = DIV_W
) (
  input  logic [DATA_W-1:0] r_in,
  input  logic [DATA_W-1:0] q_in,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] r_out,
  output logic [DATA_W-1:0] q_out
);

  logic [DATA_W:0] trial;

  always_comb begin
    // 33-bit subtract: the top bit is the borrow that decides restore vs. keep
    trial = {r_in, q_in[DATA_W-1]} - {1'b0, d_in};
    if (!trial[DATA_W]) begin
      r_out = trial[DATA_W-1:0];
      q_out = {q_in[DATA_W-2:0], 1'b1};
    end else begin
      r_out = {r_in[DATA_W-2:0], q_in[DATA_W-1]};
      q_out = {q_in[DATA_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - 32-bit DIV/DIVU unit producing LO (quotient) and HI (remainder)
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = DIV_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              is_signed,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cancel,
  output logic              busy,
  output logic              valid,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] hi,
  output logic              div_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e state_q, state_d;
  logic [DATA_W-1:0] r_q, r_d, q_q, q_d, d_q, d_d, a_q, a_d;
  logic [DATA_W-1:0] lo_q, lo_d, hi_q, hi_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              q_neg_q, q_neg_d, r_neg_q, r_neg_d;
  logic              valid_q, valid_d, dz_q, dz_d;

  logic [DATA_W-1:0] r_step, q_step, a_mag, b_mag;
  logic              a_sgn, b_sgn;

  div_step #(.DATA_W(DATA_W)) u_step (
    .r_in  (r_q),
    .q_in  (q_q),
    .d_in  (d_q),
    .r_out (r_step),
    .q_out (q_step)
  );

  always_comb begin
    a_sgn   = is_signed & a[DATA_W-1];
    b_sgn   = is_signed & b[DATA_W-1];
    a_mag   = cond_neg(a, a_sgn);
    b_mag   = cond_neg(b, b_sgn);

    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    a_d     = a_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    cnt_d   = cnt_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    valid_d = valid_q;
    dz_d    = dz_q;

    if (cancel) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
      dz_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            a_d     = a;
            d_d     = b_mag;
            q_neg_d = a_sgn ^ b_sgn;
            r_neg_d = a_sgn;
            valid_d = 1'b0;
            dz_d    = (b == '0);
            r_d     = '0;
            q_d     = a_mag;
            cnt_d   = '0;
            state_d = (b == '0) ? S_FIX : S_CALC;
          end
        end
        S_CALC: begin
          r_d   = r_step;
          q_d   = q_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = S_FIX;
        end
        S_FIX: begin
          // divide-by-zero returns the raw captured dividend, no sign fix-up
          if (dz_q) begin
            lo_d = '1;
            hi_d = a_q;
          end else begin
            lo_d = cond_neg(q_q, q_neg_q);
            hi_d = cond_neg(r_q, r_neg_q);
          end
          valid_d = 1'b1;
          state_d = S_DONE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      a_q     <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      cnt_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      valid_q <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      a_q     <= a_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      cnt_q   <= cnt_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      valid_q <= valid_d;
      dz_q    <= dz_d;
    end
  end

  assign busy     = (state_q == S_CALC) || (state_q == S_FIX);
  assign valid    = valid_q;
  assign lo       = lo_q;
  assign hi       = hi_q;
  assign div_zero = dz_q;

endmodule
